// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-atomic round-robin arbiter that shares one byte-wide
// AXI-Stream Ethernet TX path between several sources, with inter-frame gap.
module eth_tx_arbiter #(
    parameter int N_SOURCES  = 2,
    parameter int IFG_CYCLES = 48,
    parameter int CNT_WIDTH  = 16,
    localparam int GW = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [N_SOURCES*8-1:0] s_tdata,
    input  logic [N_SOURCES-1:0]   s_tvalid,
    input  logic [N_SOURCES-1:0]   s_tlast,
    input  logic [N_SOURCES-1:0]   s_tuser,
    output logic [N_SOURCES-1:0]   s_tready,
    output logic [7:0]             m_tdata,
    output logic                   m_tvalid,
    output logic                   m_tlast,
    output logic                   m_tuser,
    input  logic                   m_tready,
    output logic [GW-1:0]          grant,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   frame_count
);

    localparam int GAPW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAPW-1:0] GAP_LOAD =
        (IFG_CYCLES > 0) ? GAPW'(IFG_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        GAP
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [GW-1:0]        grant_q;
    logic [GW-1:0]        grant_d;
    logic [GW-1:0]        rr_q;
    logic [GW-1:0]        rr_d;
    logic [GAPW-1:0]      gap_q;
    logic [GAPW-1:0]      gap_d;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    logic                 pick_found;
    logic [GW-1:0]        pick_idx;
    logic [7:0]           sel_data;
    logic                 sel_valid;
    logic                 sel_last;
    logic                 sel_user;

    // Scan from rr_q upward; the lowest rotated offset with a request wins.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = N_SOURCES - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= N_SOURCES) begin
                idx = idx - N_SOURCES;
            end
            for (int i = 0; i < N_SOURCES; i++) begin
                if (i == idx && s_tvalid[i]) begin
                    pick_found = 1'b1;
                    pick_idx   = GW'(i);
                end
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        for (int i = 0; i < N_SOURCES; i++) begin
            if (GW'(i) == grant_q) begin
                sel_data  = s_tdata[8*i +: 8];
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
                sel_user  = s_tuser[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        gap_d    = gap_q;
        count_d  = count_q;
        s_tready = '0;
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tuser  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable && pick_found) begin
                    grant_d = pick_idx;
                    state_d = PASS;
                end
            end
            PASS: begin
                m_tvalid = sel_valid;
                m_tdata  = sel_valid ? sel_data : 8'h00;
                m_tlast  = sel_valid & sel_last;
                m_tuser  = sel_valid & sel_user;
                for (int i = 0; i < N_SOURCES; i++) begin
                    s_tready[i] = (GW'(i) == grant_q) && m_tready;
                end
                if (sel_valid && m_tready && sel_last) begin
                    count_d = count_q + 1'b1;
                    if (int'(grant_q) == N_SOURCES - 1) begin
                        rr_d = '0;
                    end else begin
                        rr_d = grant_q + 1'b1;
                    end
                    if (IFG_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            gap_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            gap_q   <= gap_d;
            count_q <= count_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign frame_count = count_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: scoreboard bench; stimulus queues expected bytes and
// inter-frame idle counts, an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_eth_tx_arbiter;

    localparam int IFG = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic [15:0] s_tdata;
    logic [1:0]  s_tvalid;
    logic [1:0]  s_tlast;
    logic [1:0]  s_tuser;
    logic [1:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tuser;
    logic        m_tready;
    logic [0:0]  grant;
    logic        busy;
    logic [15:0] fc;

    logic        b_rst;
    logic [15:0] b_tdata;
    logic [1:0]  b_tvalid;
    logic [1:0]  b_tlast;
    logic [1:0]  b_tuser;
    logic [1:0]  b_tready;
    logic [7:0]  b_m_tdata;
    logic        b_m_tvalid;
    logic        b_m_tlast;
    logic        b_m_tuser;
    logic [0:0]  b_grant;
    logic        b_busy;
    logic [3:0]  b_fc;

    eth_tx_arbiter #(.N_SOURCES(2), .IFG_CYCLES(IFG), .CNT_WIDTH(16)) dut_a (
        .clock(clk), .reset(rst), .enable(en),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tuser(s_tuser), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tuser(m_tuser), .m_tready(m_tready),
        .grant(grant), .busy(busy), .frame_count(fc)
    );

    eth_tx_arbiter #(.N_SOURCES(2), .IFG_CYCLES(0), .CNT_WIDTH(4)) dut_b (
        .clock(clk), .reset(b_rst), .enable(1'b1),
        .s_tdata(b_tdata), .s_tvalid(b_tvalid), .s_tlast(b_tlast),
        .s_tuser(b_tuser), .s_tready(b_tready),
        .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tlast(b_m_tlast),
        .m_tuser(b_m_tuser), .m_tready(1'b1),
        .grant(b_grant), .busy(b_busy), .frame_count(b_fc)
    );

    typedef struct {
        int         src;
        logic [7:0] data;
        logic       last;
        logic       user;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    int         gap_q[$];
    logic [9:0] src_q[2][$];
    logic [1:0] hold = 2'b00;

    task automatic check(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int s, logic [7:0] d, logic l, logic u, bit ex = 1'b1);
        exp_t e;
        src_q[s].push_back({u, l, d});
        if (ex) begin
            e.src  = s;
            e.data = d;
            e.last = l;
            e.user = u;
            exp_q.push_back(e);
        end
    endtask

    // -1 means the idle gap before this frame is not checked.
    task automatic gapx(int g);
        gap_q.push_back(g);
    endtask

    task automatic drain(int budget, string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d_left expected=0", name, exp_q.size());
            exp_q.delete();
            gap_q.delete();
        end
    endtask

    task automatic wait_byte(logic [7:0] d, int budget, string name);
        int n = 0;
        while (!(m_tvalid && m_tdata == d) && n < budget) begin
            tick();
            n++;
        end
        check(name, {m_tvalid, m_tdata}, {1'b1, d});
    endtask

    // Source models: present queue head, advance after an observed handshake.
    initial begin
        logic [1:0] hs;
        logic [9:0] h;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        s_tuser  = '0;
        forever begin
            @(negedge clk);
            hs = s_tvalid & s_tready;
            @(posedge clk);
            #2;
            for (int i = 0; i < 2; i++) begin
                if (hs[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                end
                if (src_q[i].size() > 0 && !hold[i]) begin
                    h = src_q[i][0];
                    s_tvalid[i]       = 1'b1;
                    s_tdata[8*i +: 8] = h[7:0];
                    s_tlast[i]        = h[8];
                    s_tuser[i]        = h[9];
                end else begin
                    s_tvalid[i]       = 1'b0;
                    s_tdata[8*i +: 8] = 8'h00;
                    s_tlast[i]        = 1'b0;
                    s_tuser[i]        = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every output handshake against the scoreboard.
    initial begin
        int   idle;
        bit   in_frame;
        exp_t e;
        int   g;
        idle     = 0;
        in_frame = 1'b0;
        forever begin
            @(negedge clk);
            if (!busy) begin
                check("idle_s_tready", s_tready, 0);
            end else begin
                check("other_s_tready", s_tready & ~(2'b01 << grant), 0);
            end
            if (!m_tvalid) begin
                check("idle_m_zero", {m_tdata, m_tlast, m_tuser}, 0);
            end
            if (m_tvalid && !in_frame) begin
                in_frame = 1'b1;
                g = (gap_q.size() > 0) ? gap_q.pop_front() : -1;
                if (g >= 0) begin
                    check("frame_gap", idle, g);
                end
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h expected=none", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("src", grant, e.src);
                    check("data", m_tdata, e.data);
                    check("last", m_tlast, e.last);
                    check("user", m_tuser, e.user);
                end
                if (m_tlast) begin
                    in_frame = 1'b0;
                    idle     = 0;
                end
            end else if (!m_tvalid && !in_frame) begin
                idle++;
            end
            if (rst) begin
                in_frame = 1'b0;
                idle     = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        m_tready = 1'b1;
        b_rst    = 1'b1;
        b_tdata  = '0;
        b_tvalid = '0;
        b_tlast  = '0;
        b_tuser  = '0;
        repeat (3) edge_();
        rst = 1'b0;
        tick();
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", fc, 0);
        check("rst_grant", grant, 0);

        // Single 3-byte frame, then the gap.
        gapx(-1);
        send(0, 8'hAA, 0, 0);
        send(0, 8'hBB, 0, 0);
        send(0, 8'hCC, 1, 0);
        tick();
        check("t1_arb_m_tvalid", m_tvalid, 0);
        tick();
        check("t1_first_m_tvalid", m_tvalid, 1);
        check("t1_first_busy", busy, 1);
        drain(20, "t1");
        for (int i = 0; i < IFG; i++) begin
            tick();
            check("t1_gap_busy", {busy, m_tvalid}, 2'b10);
        end
        check("t1_count", fc, 1);
        tick();
        check("t1_idle_busy", busy, 0);

        // Round robin with both sources requesting continuously.
        edge_();
        rst = 1'b1;
        edge_();
        rst = 1'b0;
        gapx(-1);
        send(0, 8'h01, 0, 0);
        send(0, 8'h02, 1, 1);
        gapx(IFG + 1);
        send(1, 8'h11, 0, 0);
        send(1, 8'h12, 1, 0);
        gapx(IFG + 1);
        send(0, 8'h03, 0, 0);
        send(0, 8'h04, 1, 0);
        gapx(IFG + 1);
        send(1, 8'h13, 0, 0);
        send(1, 8'h14, 1, 0);
        drain(100, "t2");
        repeat (IFG + 1) tick();
        check("t2_count", fc, 4);
        check("t2_busy", busy, 0);

        // Stalls and a source bubble on source 1 with source 0 waiting.
        gapx(-1);
        send(0, 8'hA0, 1, 0);
        gapx(IFG + 1);
        send(1, 8'h11, 0, 0);
        send(1, 8'h22, 0, 0);
        send(1, 8'h33, 0, 0);
        send(1, 8'h44, 1, 0);
        gapx(IFG + 1);
        send(0, 8'hB0, 1, 0);
        wait_byte(8'h11, 40, "t3_find_11");
        edge_();
        m_tready = 1'b0;
        tick();
        check("t3_stall", {m_tvalid, m_tdata, s_tready}, {1'b1, 8'h22, 2'b00});
        edge_();
        edge_();
        m_tready = 1'b1;
        edge_();
        hold[1] = 1'b1;
        tick();
        check("t3_bubble", {m_tvalid, busy, grant}, 3'b011);
        edge_();
        hold[1] = 1'b0;
        drain(60, "t3");
        repeat (IFG + 1) tick();
        check("t3_count", fc, 7);

        // Enable gating and mid-frame enable drop.
        edge_();
        en = 1'b0;
        gapx(-1);
        send(0, 8'hC1, 0, 0);
        send(0, 8'hC2, 0, 0);
        send(0, 8'hC3, 1, 0);
        repeat (4) begin
            tick();
            check("t4_blocked", {busy, m_tvalid}, 2'b00);
        end
        edge_();
        en = 1'b1;
        tick();
        check("t4_arb", {busy, m_tvalid}, 2'b00);
        tick();
        check("t4_granted", {busy, m_tvalid, grant}, 3'b110);
        edge_();
        en = 1'b0;
        drain(20, "t4");
        repeat (IFG + 1) tick();
        check("t4_count", fc, 8);
        gapx(-1);
        send(1, 8'hD1, 1, 0);
        repeat (4) begin
            tick();
            check("t4_blocked2", {busy, m_tvalid}, 2'b00);
        end
        edge_();
        en = 1'b1;
        drain(20, "t4b");
        repeat (IFG + 1) tick();
        check("t4b_count", fc, 9);

        // Reset during the second byte of a 5-byte frame from source 1.
        gapx(-1);
        send(0, 8'hE0, 1, 0);
        drain(20, "t5a");
        repeat (IFG + 1) tick();
        gapx(-1);
        send(1, 8'hE1, 0, 0);
        send(1, 8'hE2, 0, 0);
        send(1, 8'hE3, 0, 0, 1'b0);
        send(1, 8'hE4, 0, 0, 1'b0);
        send(1, 8'hE5, 1, 0, 1'b0);
        wait_byte(8'hE1, 40, "t5_find_e1");
        edge_();
        rst = 1'b1;
        edge_();
        rst = 1'b0;
        src_q[0].delete();
        src_q[1].delete();
        tick();
        check("t5_m_tvalid", m_tvalid, 0);
        check("t5_s_tready", s_tready, 0);
        check("t5_count", fc, 0);
        check("t5_busy", busy, 0);
        check("t5_grant", grant, 0);
        check("t5_truncated", exp_q.size(), 0);
        gapx(-1);
        send(0, 8'hF0, 1, 0);
        gapx(IFG + 1);
        send(1, 8'hF1, 1, 0);
        drain(40, "t5b");
        repeat (IFG + 1) tick();
        check("t5b_count", fc, 2);

        // IFG=0, 4-bit counter: one idle cycle per frame and a wrap.
        edge_();
        b_rst    = 1'b0;
        b_tvalid = 2'b01;
        b_tlast  = 2'b01;
        b_tdata  = 16'h0000;
        for (int k = 0; k < 17; k++) begin
            tick();
            check("b_idle", b_m_tvalid, 0);
            tick();
            check("b_byte", {b_m_tvalid, b_m_tdata}, {1'b1, 8'(k)});
            edge_();
            b_tdata = 16'(k + 1);
            if (k == 14) check("b_count15", b_fc, 15);
            if (k == 15) check("b_wrap", b_fc, 0);
            if (k == 16) check("b_count17", b_fc, 1);
        end
        b_tvalid = 2'b00;
        b_tlast  = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
